// File: rtl/order_nd_stream.sv
// order_nd_stream: pipelined odd-even transposition sorter for N elements with valid/ready
// flow control, per-vector direction and a rank-select tap on the sorted output.
module order_nd_stream #(
  parameter  int unsigned DSIZE      = 64,
  parameter  int unsigned N          = 25,
  parameter  int unsigned PIPE_EVERY = 5,
  localparam int unsigned RSIZE      = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DSIZE-1:0]   in_data,
  input  logic                 in_ascend,
  input  logic [RSIZE-1:0]     rank_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*DSIZE-1:0]   od,
  output logic [DSIZE-1:0]     od_rank
);

  localparam int unsigned L  = (N + PIPE_EVERY - 1) / PIPE_EVERY;
  localparam int unsigned VW = N * DSIZE;

  logic [L-1:0]     v_q;
  logic [L-1:0]     asc_q;
  logic [VW-1:0]    data_q [L];
  logic [RSIZE-1:0] rs_q   [L];

  logic [L-1:0]     adv;
  logic [L:0]       v_chain;
  logic [L:0]       asc_chain;
  logic [VW-1:0]    chain    [L+1];
  logic [RSIZE-1:0] rs_chain [L+1];
  logic [VW-1:0]    nxt      [L];

  // One transposition phase; pairs are disjoint so reading the input vector is safe.
  function automatic logic [VW-1:0] phase_step(input logic [VW-1:0] d, input logic asc,
                                               input int unsigned p);
    logic [VW-1:0]    r;
    logic [DSIZE-1:0] a;
    logic [DSIZE-1:0] b;
    r = d;
    for (int unsigned j = 0; j + 1 < N; j++) begin
      if ((j % 2) == (p % 2)) begin
        a = d[j*DSIZE +: DSIZE];
        b = d[(j+1)*DSIZE +: DSIZE];
        if (asc ? (a > b) : (a < b)) begin
          r[j*DSIZE +: DSIZE]     = b;
          r[(j+1)*DSIZE +: DSIZE] = a;
        end
      end
    end
    return r;
  endfunction

  // A stage advances if it is empty or the stage below it advances.
  always_comb begin
    logic acc;
    adv = '0;
    for (int unsigned i = 0; i < L; i++) begin
      acc = out_ready;
      for (int unsigned j = i; j < L; j++) begin
        acc = acc | ~v_q[j];
      end
      adv[i] = acc;
    end
  end

  assign in_ready  = adv[0];
  assign v_chain   = {v_q, in_valid};
  assign asc_chain = {asc_q, in_ascend};

  // Stage i takes its source from chain[i]: the input port for stage 0, else stage i-1.
  always_comb begin
    logic [VW-1:0] w;
    chain[0]    = in_data;
    rs_chain[0] = rank_sel;
    for (int unsigned i = 0; i < L; i++) begin
      chain[i+1]    = data_q[i];
      rs_chain[i+1] = rs_q[i];
    end
    for (int unsigned i = 0; i < L; i++) begin
      w = chain[i];
      for (int unsigned k = 0; k < PIPE_EVERY; k++) begin
        if (i * PIPE_EVERY + k < N) begin
          w = phase_step(w, asc_chain[i], i * PIPE_EVERY + k);
        end
      end
      nxt[i] = w;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int unsigned i = 0; i < L; i++) begin
        v_q[i]    <= 1'b0;
        asc_q[i]  <= 1'b1;
        data_q[i] <= '0;
        rs_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < L; i++) begin
        if (adv[i]) begin
          v_q[i]    <= v_chain[i];
          asc_q[i]  <= asc_chain[i];
          data_q[i] <= nxt[i];
          rs_q[i]   <= rs_chain[i];
        end
      end
    end
  end

  assign out_valid = v_q[L-1];
  assign od        = data_q[L-1];

  // Rank tap on the registered output; out-of-range selects clamp to the last element.
  always_comb begin
    int unsigned idx;
    idx = 32'(rs_q[L-1]);
    if (idx > N - 1) begin
      idx = N - 1;
    end
    od_rank = od[idx*DSIZE +: DSIZE];
  end

endmodule

// File: tb/tb_order_nd_stream.sv
// Directed bench for order_nd_stream: a 25-element/5-phase instance and a 4-element/1-phase instance.
module tb_order_nd_stream;

  localparam int unsigned DW = 64;
  localparam int unsigned NB = 25;
  localparam int unsigned LB = 5;
  localparam int unsigned NS = 4;
  localparam int unsigned NV = 20;

  logic              clock = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_ascend, out_valid, out_ready;
  logic [NB*DW-1:0]  in_data, od;
  logic [4:0]        rank_sel;
  logic [DW-1:0]     od_rank;

  logic              s_in_valid, s_in_ready, s_in_ascend, s_out_valid, s_out_ready;
  logic [NS*DW-1:0]  s_in_data, s_od;
  logic [1:0]        s_rank_sel;
  logic [DW-1:0]     s_od_rank;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clock = ~clock;

  order_nd_stream #(.DSIZE(DW), .N(NB), .PIPE_EVERY(5)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ascend(in_ascend), .rank_sel(rank_sel), .out_valid(out_valid), .out_ready(out_ready),
    .od(od), .od_rank(od_rank)
  );

  order_nd_stream #(.DSIZE(DW), .N(NS), .PIPE_EVERY(1)) dut4 (
    .clock(clock), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_ascend(s_in_ascend), .rank_sel(s_rank_sel), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .od(s_od), .od_rank(s_od_rank)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Element k = tag*1000 + (7k mod 25): a permutation of tag*1000 + 0..24.
  function automatic logic [NB*DW-1:0] perm_vec(input int unsigned tag);
    logic [NB*DW-1:0] v;
    for (int unsigned k = 0; k < NB; k++) v[k*DW +: DW] = DW'(tag * 1000 + (k * 7) % 25);
    return v;
  endfunction

  function automatic logic [NB*DW-1:0] sorted_vec(input int unsigned tag, input logic asc);
    logic [NB*DW-1:0] v;
    for (int unsigned k = 0; k < NB; k++)
      v[k*DW +: DW] = asc ? DW'(tag * 1000 + k) : DW'(tag * 1000 + 24 - k);
    return v;
  endfunction

  function automatic logic [NB*DW-1:0] down_vec();
    logic [NB*DW-1:0] v;
    for (int unsigned k = 0; k < NB; k++) v[k*DW +: DW] = DW'(24 - k);
    return v;
  endfunction

  function automatic logic [NB*DW-1:0] up_vec();
    logic [NB*DW-1:0] v;
    for (int unsigned k = 0; k < NB; k++) v[k*DW +: DW] = DW'(k);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (od !== '0) $display("FAIL reset_od got %h want 0", od); else n_pass++;
    n_total++; if (od_rank !== '0) $display("FAIL reset_od_rank got %h want 0", od_rank); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (s_out_valid !== 1'b0) $display("FAIL reset_small_out_valid got %b want 0", s_out_valid); else n_pass++;
  endtask

  task automatic test_ascend();
    out_ready = 1'b1;
    in_data   = down_vec();
    in_ascend = 1'b1;
    rank_sel  = 5'd12;
    in_valid  = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL asc_in_ready got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < int'(LB); c++) begin
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL asc_early_valid cycle %0d got %b want 0", c, out_valid);
      else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b1) $display("FAIL asc_latency got %b want 1", out_valid); else n_pass++;
    n_total++; if (od !== up_vec()) $display("FAIL asc_od got %h want %h", od, up_vec()); else n_pass++;
    n_total++; if (od_rank !== DW'(12)) $display("FAIL asc_od_rank got %0d want 12", od_rank); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL asc_single got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_descend_rank();
    out_ready = 1'b1;
    in_data   = down_vec();
    in_ascend = 1'b0;
    rank_sel  = 5'd0;
    in_valid  = 1'b1;
    tick();
    rank_sel  = 5'd31;
    tick();
    in_valid  = 1'b0;
    for (int c = 0; c < 20 && out_valid !== 1'b1; c++) tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL desc_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (od !== down_vec()) $display("FAIL desc_od got %h want %h", od, down_vec()); else n_pass++;
    n_total++; if (od_rank !== DW'(24)) $display("FAIL desc_rank0 got %0d want 24", od_rank); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL desc_b2b_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (od_rank !== DW'(0)) $display("FAIL desc_rank31_clamp got %0d want 0", od_rank); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL desc_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [NB*DW-1:0] held;
    out_ready = 1'b0;
    in_ascend = 1'b1;
    for (int unsigned j = 0; j < 6; j++) begin
      in_data  = perm_vec(j + 1);
      rank_sel = 5'(j);
      in_valid = 1'b1;
      #1;
      n_total++;
      if (in_ready !== (j < 5)) $display("FAIL b2b_in_ready vec %0d got %b want %b", j, in_ready, j < 5);
      else n_pass++;
      tick();
    end
    in_valid = 1'b0;
    held = od;
    tick();
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_stall_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (od !== held) $display("FAIL b2b_stall_od got %h want %h", od, held); else n_pass++;
    out_ready = 1'b1;
    for (int unsigned j = 0; j < 5; j++) begin
      n_total++;
      if (out_valid !== 1'b1 || od !== sorted_vec(j + 1, 1'b1))
        $display("FAIL b2b_drain vec %0d got v=%b %h want %h", j, out_valid, od, sorted_vec(j + 1, 1'b1));
      else n_pass++;
      n_total++;
      if (od_rank !== DW'((j + 1) * 1000 + j))
        $display("FAIL b2b_rank vec %0d got %0d want %0d", j, od_rank, (j + 1) * 1000 + j);
      else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random_flow();
    int unsigned q[$];
    int unsigned sent = 0;
    int unsigned got  = 0;
    int unsigned tag, r;
    logic gap = 1'b0;
    logic acc;
    logic asc;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 600 && got < NV; cyc++) begin
      out_ready = (cyc >= 500) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!in_valid) begin
        if (gap) gap = 1'b0;
        else if (sent < NV) begin
          in_data   = perm_vec(sent + 10);
          in_ascend = (sent % 2) == 0;
          rank_sel  = 5'((sent * 3) % 32);
          in_valid  = 1'b1;
        end
      end
      #1;
      n_total++;
      if (q.size() < LB && in_ready !== 1'b1)
        $display("FAIL flow_bubble cyc %0d occupancy %0d in_ready %b want 1", cyc, q.size(), in_ready);
      else n_pass++;
      if (out_valid === 1'b1 && out_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL flow_spurious cyc %0d got out_valid 1 want 0", cyc);
        else begin
          tag = q.pop_front();
          asc = (tag % 2) == 0;
          r   = ((tag * 3) % 32 > 24) ? 24 : (tag * 3) % 32;
          if (od !== sorted_vec(tag + 10, asc) ||
              od_rank !== (asc ? DW'((tag + 10) * 1000 + r) : DW'((tag + 10) * 1000 + 24 - r)))
            $display("FAIL flow_order vec %0d got od %h rank %0d", tag, od, od_rank);
          else n_pass++;
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(sent);
        sent++;
      end
      tick();
      if (acc) begin
        in_valid = 1'b0;
        gap      = 1'b1;
      end
    end
    n_total++; if (got !== NV) $display("FAIL flow_count got %0d want %0d", got, NV); else n_pass++;
    n_total++; if (q.size() != 0) $display("FAIL flow_leftover got %0d want 0", q.size()); else n_pass++;
  endtask

  task automatic test_small_n();
    logic [NS*DW-1:0] vin  [4];
    logic [NS*DW-1:0] vexp [4];
    logic [DW-1:0]    rexp [4];
    logic [1:0]       rsel [4];
    logic             vasc [4];
    logic [DW-1:0]    ones;
    ones    = '1;
    vin[0]  = {DW'(7), DW'(3), DW'(7), DW'(7)};
    vexp[0] = {DW'(7), DW'(7), DW'(7), DW'(3)};
    vasc[0] = 1'b1; rsel[0] = 2'd0; rexp[0] = DW'(3);
    vin[1]  = {DW'(5), DW'(5), DW'(5), DW'(5)};
    vexp[1] = vin[1];
    vasc[1] = 1'b1; rsel[1] = 2'd2; rexp[1] = DW'(5);
    vin[2]  = {DW'(1), ones, DW'(0), ones};
    vexp[2] = {ones, ones, DW'(1), DW'(0)};
    vasc[2] = 1'b1; rsel[2] = 2'd3; rexp[2] = ones;
    vin[3]  = vin[2];
    vexp[3] = {DW'(0), DW'(1), ones, ones};
    vasc[3] = 1'b0; rsel[3] = 2'd3; rexp[3] = DW'(0);
    s_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      s_in_data   = vin[j];
      s_in_ascend = vasc[j];
      s_rank_sel  = rsel[j];
      s_in_valid  = 1'b1;
      tick();
    end
    s_in_valid = 1'b0;
    // First vector accepted 4 edges ago, so with L=4 it is in the final stage now.
    for (int j = 0; j < 4; j++) begin
      n_total++;
      if (s_out_valid !== 1'b1 || s_od !== vexp[j])
        $display("FAIL small_od vec %0d got v=%b %h want %h", j, s_out_valid, s_od, vexp[j]);
      else n_pass++;
      n_total++;
      if (s_od_rank !== rexp[j]) $display("FAIL small_rank vec %0d got %h want %h", j, s_od_rank, rexp[j]);
      else n_pass++;
      tick();
    end
    n_total++; if (s_out_valid !== 1'b0) $display("FAIL small_drain got %b want 0", s_out_valid); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic seen = 1'b0;
    out_ready = 1'b1;
    in_ascend = 1'b1;
    rank_sel  = 5'd3;
    for (int unsigned j = 0; j < 3; j++) begin
      in_data  = perm_vec(50 + j);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (od !== '0) $display("FAIL mrst_od got %h want 0", od); else n_pass++;
    n_total++; if (od_rank !== '0) $display("FAIL mrst_od_rank got %h want 0", od_rank); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL mrst_in_ready got %b want 1", in_ready); else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL mrst_stale got %b want 0", seen); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ascend = 1'b1; rank_sel = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_ascend = 1'b1; s_rank_sel = '0; s_out_ready = 1'b1;
    test_reset();
    test_ascend();
    test_descend_rank();
    test_back_to_back();
    test_random_flow();
    test_small_n();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
